mul_uint8_seq: RTL and testbench

Sequential controller for 8-bit unsigned multiplication: sequences a small radix-4 partial-product stage over multiple cycles rather than instantiating a full combinational array. It accepts operands over a valid/ready handshake, iterates over the multiplier two bits per cycle, and returns the full 16-bit product plus a truncation flag for consumers that keep only the low byte. It is the area-lean alternative to the combinational unsigned multipliers in the misc library.

---
 rtl/mul_seq_pkg.sv | 19 +
 rtl/mul_pp_radix4.sv | 22 ++
 rtl/mul_uint8_seq.sv | 93 +++++++++
 tb/tb_mul_uint8_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types and sizing for the sequential radix-4 unsigned multiplier.
// Sizing constants describe the default 8-bit build; cnt_width() sizes other widths.
package mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 8;
    localparam int STEPS     = WIDTH_DEF / 2;
    localparam int CNT_W     = $clog2(STEPS);

    function automatic int cnt_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/mul_pp_radix4.sv
// Radix-4 partial product: selects 0, 1x, 2x or 3x the shifted multiplicand.
// Latency: combinational.
// Backpressure: none, pure datapath.
module mul_pp_radix4 #(
    parameter int WIDTH = 8
) (
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [1:0]         digit,
    output logic [2*WIDTH-1:0] pp
);

    always_comb begin
        pp = '0;
        unique case (digit)
            2'd0:    pp = '0;
            2'd1:    pp = mcand;
            2'd2:    pp = mcand << 1;
            default: pp = mcand + (mcand << 1);
        endcase
    end

endmodule

// File: rtl/mul_uint8_seq.sv
// Sequential unsigned multiplier retiring two multiplier bits per CALC cycle.
// Latency: 1 accept + k CALC steps (k=WIDTH/2, or fewer with EARLY_EXIT) + 1 DONE.
// Backpressure: holds p/ovf in DONE until out_ready; in_ready only in IDLE.
module mul_uint8_seq
    import mul_seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               ovf,
    output logic               busy
);

    localparam int PW      = 2 * WIDTH;
    localparam int STEPS_P = WIDTH / 2;
    localparam int CNT_WP  = cnt_width(STEPS_P);

    state_t             state;
    logic [PW-1:0]      mcand;
    logic [PW-1:0]      acc;
    logic [PW-1:0]      pp;
    logic [PW-1:0]      acc_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   mplier_nxt;
    logic [CNT_WP-1:0]  cnt;
    logic               last_step;

    mul_pp_radix4 #(.WIDTH(WIDTH)) u_pp (
        .mcand (mcand),
        .digit (mplier[1:0]),
        .pp    (pp)
    );

    assign acc_nxt    = acc + pp;
    assign mplier_nxt = mplier >> 2;
    // Early exit looks at the multiplier after this step's shift: nothing left to add.
    assign last_step  = (cnt == CNT_WP'(STEPS_P - 1)) || (EARLY_EXIT && (mplier_nxt == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            p      <= '0;
            ovf    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= {{WIDTH{1'b0}}, a};
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 2;
                    mplier <= mplier_nxt;
                    cnt    <= cnt + 1'b1;
                    if (last_step) begin
                        p     <= acc_nxt;
                        ovf   <= |acc_nxt[PW-1:WIDTH];
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mul_uint8_seq.sv
// Scoreboard bench: instance 0 runs EARLY_EXIT=0, instance 1 runs EARLY_EXIT=1.
module tb_mul_uint8_seq;

    typedef struct packed {
        logic [15:0] p;
        logic        ovf;
        logic [7:0]  k;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic        busy      [2];
    logic        ovf       [2];
    logic [7:0]  a_s       [2];
    logic [7:0]  b_s       [2];
    logic [15:0] p         [2];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc [2];
    int acc_cnt [2];
    int dcyc    [2];
    bit prev_ov [2];
    exp_t q0[$];
    exp_t q1[$];
    logic [16:0] got0[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul_uint8_seq #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a_s[0]), .b(b_s[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .p(p[0]), .ovf(ovf[0]), .busy(busy[0])
    );

    mul_uint8_seq #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a_s[1]), .b(b_s[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .p(p[1]), .ovf(ovf[1]), .busy(busy[1])
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain product, and step count from the highest set multiplier bit.
    function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv, input bit ee);
        exp_t e;
        int prod;
        int k;
        prod = int'(av) * int'(bv);
        k = 4;
        if (ee) begin
            k = 1;
            for (int j = 0; j < 8; j++) if (bv[j]) k = j / 2 + 1;
        end
        e.p   = prod[15:0];
        e.ovf = (prod > 255);
        e.k   = 8'(k);
        return e;
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    task automatic mon(input int i);
        exp_t e;
        if (out_valid[i] && !prev_ov[i]) begin
            if (qsize(i) == 0) chk($sformatf("unexpected_valid%0d", i), 1, 0);
            else begin
                e = (i == 0) ? q0[0] : q1[0];
                chk($sformatf("latency%0d", i), cyc - acc_cyc[i], int'(e.k));
            end
        end
        if (out_valid[i] && out_ready[i]) begin
            if (qsize(i) == 0) chk($sformatf("spurious_out%0d", i), 1, 0);
            else begin
                e = (i == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("sb_p%0d", i), int'(p[i]), int'(e.p));
                chk($sformatf("sb_ovf%0d", i), int'(ovf[i]), int'(e.ovf));
                if (i == 0) got0.push_back({ovf[0], p[0]});
            end
        end
        if (out_valid[i]) dcyc[i]++;
        if (in_valid[i] && in_ready[i]) begin
            e = model(a_s[i], b_s[i], i == 1);
            if (i == 0) q0.push_back(e);
            else q1.push_back(e);
            acc_cyc[i] = cyc + 1;
            acc_cnt[i]++;
        end
        prev_ov[i] = out_valid[i];
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) mon(i);
        end
    end

    task automatic wait_accept(input int i);
        int g = 0;
        @(negedge clk);
        while (!in_ready[i] && g < 50) begin @(negedge clk); g++; end
        if (g >= 50) chk($sformatf("accept_timeout%0d", i), 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic op(input int i, input logic [7:0] av, input logic [7:0] bv,
                      input int ep, input int eovf, input int ek);
        int g;
        @(posedge clk); #1;
        a_s[i] = av; b_s[i] = bv; in_valid[i] = 1'b1; out_ready[i] = 1'b0;
        wait_accept(i);
        in_valid[i] = 1'b0;
        g = 0;
        do begin @(negedge clk); g++; end while (!out_valid[i] && g < 50);
        chk($sformatf("op_valid%0d", i), int'(out_valid[i]), 1);
        chk($sformatf("op_steps%0d", i), g - 1, ek);
        chk($sformatf("op_p%0d", i), int'(p[i]), ep);
        chk($sformatf("op_ovf%0d", i), int'(ovf[i]), eovf);
        chk($sformatf("op_busy%0d", i), int'(busy[i]), 1);
        @(posedge clk); #1 out_ready[i] = 1'b1;
        @(posedge clk); #1 out_ready[i] = 1'b0;
    endtask

    task automatic run_rand(input int i, input int n);
        int g = 0;
        logic [7:0] bv;
        acc_cnt[i] = 0;
        while (acc_cnt[i] < n && g < 60000) begin
            @(posedge clk); #1; g++;
            bv = 8'($urandom);
            in_valid[i]  = ($urandom_range(0, 3) != 0);
            a_s[i]       = 8'($urandom);
            b_s[i]       = bv >> $urandom_range(0, 8);
            out_ready[i] = ($urandom_range(0, 2) != 0);
        end
        @(posedge clk); #1 in_valid[i] = 1'b0; out_ready[i] = 1'b1;
        g = 0;
        while (qsize(i) != 0 && g < 100) begin @(posedge clk); g++; end
        chk($sformatf("rand_drain%0d", i), qsize(i), 0);
        chk($sformatf("rand_count%0d", i), int'(acc_cnt[i] >= n), 1);
        out_ready[i] = 1'b0;
    endtask

    initial begin
        int g;
        logic [7:0] sa [3];
        logic [7:0] sb [3];
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; out_ready[i] = 1'b0; a_s[i] = '0; b_s[i] = '0;
            acc_cyc[i] = 0; acc_cnt[i] = 0; dcyc[i] = 0; prev_ov[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_in_ready%0d", i), int'(in_ready[i]), 1);
            chk($sformatf("rst_out_valid%0d", i), int'(out_valid[i]), 0);
            chk($sformatf("rst_busy%0d", i), int'(busy[i]), 0);
            chk($sformatf("rst_p%0d", i), int'(p[i]), 0);
            chk($sformatf("rst_ovf%0d", i), int'(ovf[i]), 0);
        end
        rst_n = 1'b1;

        // Abort an operation two edges into CALC.
        @(posedge clk); #1;
        a_s[0] = 8'hFF; b_s[0] = 8'hFF; in_valid[0] = 1'b1;
        wait_accept(0);
        in_valid[0] = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("midcalc_out_valid", int'(out_valid[0]), 0);
        chk("midcalc_in_ready", int'(in_ready[0]), 1);
        chk("midcalc_p", int'(p[0]), 0);
        q0.delete(); q1.delete();
        prev_ov[0] = 1'b0; prev_ov[1] = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        op(0, 8'd3, 8'd5, 16'h000F, 0, 4);

        op(0, 8'hFF, 8'hFF, 16'hFE01, 1, 4);

        op(1, 8'h5A, 8'h00, 16'h0000, 0, 1);
        op(1, 8'h10, 8'h03, 16'h0030, 0, 1);
        op(1, 8'h02, 8'h80, 16'h0100, 1, 4);

        // Stall in DONE with a competing request held on the input.
        @(posedge clk); #1;
        a_s[0] = 8'h12; b_s[0] = 8'h34; in_valid[0] = 1'b1; out_ready[0] = 1'b0;
        wait_accept(0);
        a_s[0] = 8'hAA; b_s[0] = 8'h55;
        g = 0;
        do begin @(negedge clk); g++; end while (!out_valid[0] && g < 50);
        for (int c = 0; c < 10; c++) begin
            chk("bp_p", int'(p[0]), 16'h03A8);
            chk("bp_out_valid", int'(out_valid[0]), 1);
            chk("bp_in_ready", int'(in_ready[0]), 0);
            @(negedge clk);
        end
        @(posedge clk); #1 in_valid[0] = 1'b0; out_ready[0] = 1'b1;
        @(posedge clk); #1 out_ready[0] = 1'b0;
        @(negedge clk);
        chk("bp_queue_empty", q0.size(), 0);

        // Back-to-back stream with the consumer always ready.
        sa[0] = 8'h07; sb[0] = 8'h09;
        sa[1] = 8'hFF; sb[1] = 8'h01;
        sa[2] = 8'h10; sb[2] = 8'h10;
        got0.delete(); dcyc[0] = 0;
        @(posedge clk); #1 out_ready[0] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            a_s[0] = sa[j]; b_s[0] = sb[j]; in_valid[0] = 1'b1;
            wait_accept(0);
        end
        in_valid[0] = 1'b0;
        g = 0;
        while (got0.size() < 3 && g < 50) begin @(posedge clk); g++; end
        #1;
        chk("b2b_count", got0.size(), 3);
        if (got0.size() == 3) begin
            chk("b2b_0", int'(got0[0]), 17'h0003F);
            chk("b2b_1", int'(got0[1]), 17'h000FF);
            chk("b2b_2", int'(got0[2]), 17'h10100);
        end
        chk("b2b_done_cycles", dcyc[0], 3);
        out_ready[0] = 1'b0;

        fork
            run_rand(0, 3000);
            run_rand(1, 3000);
        join

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
